ecc_scrub_ctrl: RTL and testbench

Background memory scrubber that sequences the team's combinational ECC decoder (32-bit codeword in, 32-bit corrected word out, err_2_bit flag) over a single-port memory.
- Walks every address, reads the stored codeword and presents it to the decoder.
- Writes back single-bit-corrected words; logs double-bit (uncorrectable) errors.
- Shares the memory port with a host, which always has priority.

---
 rtl/ecc_scrub_pkg.sv | 17 +
 rtl/sat_counter.sv | 24 ++
 rtl/ecc_scrub_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_scrub_pkg.sv
// Shared types for the ECC scrubber: FSM state encoding and data word width.
// Latency: n/a (types only).
// Backpressure: n/a.
package ecc_scrub_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPT,
      CHECK,
      WRITE,
      NEXT
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency: count updates one cycle after clear/inc.
// Backpressure: none; inc is ignored once saturated.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: reads each word, runs it through the external decoder, writes back corrections.
// Latency: 4 cycles per clean word, 5 per corrected word, plus host stall cycles.
// Backpressure: host_req stalls READ/WRITE. Optional auto-start timer: ECC_SCRUB_TIMER_EN.
module ecc_scrub_ctrl
   import ecc_scrub_pkg::*;
#(
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 8,
   parameter int CNT_W    = 16,
   parameter int INTERVAL = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              host_req,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [WORD_W-1:0] ecc_data_in,
   input  logic [WORD_W-1:0] ecc_data_out,
   input  logic              ecc_err_2_bit,
   output logic [CNT_W-1:0]  corr_count,
   output logic [CNT_W-1:0]  uncorr_count,
   output logic [ADDR_W-1:0] last_uncorr_addr,
   output logic              uncorr_flag
);

   generate
      if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
         $error("ecc_scrub_ctrl: ADDR_W too narrow for DEPTH");
      end
      if (INTERVAL < 1) begin : g_bad_interval
         $error("ecc_scrub_ctrl: INTERVAL must be positive");
      end
   endgenerate

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [WORD_W-1:0]   raw_q;
   logic [WORD_W-1:0]   wdata_q;
   logic                start_go;
   logic                accept;
   logic                last_addr;
   logic                corr_inc;
   logic                uncorr_inc;

`ifdef ECC_SCRUB_TIMER_EN
   // Idle timer restarts whenever a pass is running, so it reloads at every pass end.
   logic [31:0] timer_q;
   logic        auto_go;

   assign auto_go = (state_q == IDLE) && (timer_q >= 32'(INTERVAL - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else if ((state_q != IDLE) || start_go) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + 32'd1;
      end
   end

   assign start_go = start | auto_go;
`else
   assign start_go = start;
`endif

   assign accept    = (state_q == IDLE) && start_go;
   assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_go) state_d = READ;
         READ:    if (!host_req) state_d = CAPT;
         CAPT:    state_d = CHECK;
         CHECK: begin
            if (ecc_err_2_bit) begin
               state_d = NEXT;
            end else if (ecc_data_out != raw_q) begin
               state_d = WRITE;
            end else begin
               state_d = NEXT;
            end
         end
         WRITE:   if (!host_req) state_d = NEXT;
         NEXT:    state_d = last_addr ? IDLE : READ;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      done       = 1'b0;
      corr_inc   = 1'b0;
      uncorr_inc = 1'b0;
      case (state_q)
         READ:  mem_en = !host_req;
         CHECK: uncorr_inc = ecc_err_2_bit;
         WRITE: begin
            mem_en   = !host_req;
            mem_we   = !host_req;
            corr_inc = !host_req;
         end
         NEXT:  done = last_addr;
         default: ;
      endcase
   end

   // The done cycle is still in NEXT, but busy already drops there.
   assign busy        = (state_q != IDLE) && !done;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign ecc_data_in = raw_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q           <= '0;
         raw_q            <= '0;
         wdata_q          <= '0;
         last_uncorr_addr <= '0;
         uncorr_flag      <= 1'b0;
      end else begin
         if (accept) begin
            addr_q           <= '0;
            last_uncorr_addr <= '0;
            uncorr_flag      <= 1'b0;
         end else if ((state_q == NEXT) && !last_addr) begin
            addr_q <= addr_q + 1'b1;
         end
         if (state_q == CAPT) begin
            raw_q <= mem_rdata;
         end
         if (state_q == CHECK) begin
            if (ecc_err_2_bit) begin
               last_uncorr_addr <= addr_q;
               uncorr_flag      <= 1'b1;
            end else if (ecc_data_out != raw_q) begin
               wdata_q <= ecc_data_out;
            end
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_corr_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (accept),
      .inc   (corr_inc),
      .count (corr_count)
   );

   sat_counter #(.W(CNT_W)) u_uncorr_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (accept),
      .inc   (uncorr_inc),
      .count (uncorr_count)
   );

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a memory model, decoder model and write-back scoreboard.
module tb_ecc_scrub_ctrl;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int CNT_W  = 2;

   logic              clk;
   logic              rst;
   logic              start;
   logic              host_req;
   logic              busy;
   logic              done;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic [31:0]       ecc_data_in;
   logic [31:0]       ecc_data_out;
   logic              ecc_err_2_bit;
   logic [CNT_W-1:0]  corr_count;
   logic [CNT_W-1:0]  uncorr_count;
   logic [ADDR_W-1:0] last_uncorr_addr;
   logic              uncorr_flag;

   int checks = 0;
   int errors = 0;

   logic [31:0]       mem [DEPTH];
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [31:0]       ld_data;

   logic [ADDR_W-1:0] exp_addr_q [$];
   logic [31:0]       exp_data_q [$];

   ecc_scrub_ctrl #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .INTERVAL(100)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .host_req         (host_req),
      .busy             (busy),
      .done             (done),
      .mem_en           (mem_en),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .ecc_data_in      (ecc_data_in),
      .ecc_data_out     (ecc_data_out),
      .ecc_err_2_bit    (ecc_err_2_bit),
      .corr_count       (corr_count),
      .uncorr_count     (uncorr_count),
      .last_uncorr_addr (last_uncorr_addr),
      .uncorr_flag      (uncorr_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decoder model: top nibble 0xE marks uncorrectable, odd words have a flipped bit 0.
   always_comb begin
      ecc_err_2_bit = 1'b0;
      ecc_data_out  = ecc_data_in;
      if (ecc_data_in[31:28] == 4'hE) begin
         ecc_err_2_bit = 1'b1;
      end else if (ecc_data_in[0]) begin
         ecc_data_out = {ecc_data_in[31:1], 1'b0};
      end
   end

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (mem_en && mem_we && !rst) begin
         check("write_was_expected", 32'(exp_addr_q.size() != 0), 32'd1);
         if (exp_addr_q.size() != 0) begin
            check("write_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            check("write_data", mem_wdata, exp_data_q.pop_front());
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_ecc_data_in"}, ecc_data_in, 32'd0);
      check({tag, "_corr"}, 32'(corr_count), 32'd0);
      check({tag, "_uncorr"}, 32'(uncorr_count), 32'd0);
      check({tag, "_last_addr"}, 32'(last_uncorr_addr), 32'd0);
      check({tag, "_flag"}, 32'(uncorr_flag), 32'd0);
   endtask

   task automatic load_word(input int a, input logic [31:0] d);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = ADDR_W'(a);
      ld_data = d;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   task automatic load_clean();
      for (int i = 0; i < DEPTH; i++) load_word(i, 32'h1000_0000 + 32'(i << 4));
   endtask

   task automatic expect_write(input int a, input logic [31:0] d);
      exp_addr_q.push_back(ADDR_W'(a));
      exp_data_q.push_back(d);
   endtask

   // Pulses start and counts cycles to done; optionally holds the host off a READ or resets in a WRITE.
   task automatic run_pass(input int hold_addr, input int rst_addr, output int lat, output int first_addr);
      int n;
      int hold_left;
      bit held;
      lat        = -1;
      first_addr = -1;
      hold_left  = 0;
      held       = 1'b0;
      @(negedge clk);
      start = 1'b1;
      n = 0;
      while (n < 600) begin
         @(negedge clk);
         start = 1'b0;
         n++;
         #1;
         if (first_addr < 0 && mem_en) first_addr = int'(mem_addr);
         if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) host_req = 1'b0;
            else check("hold_mem_en", 32'(mem_en), 32'd0);
         end else if (hold_addr >= 0 && !held && mem_en && !mem_we && int'(mem_addr) == hold_addr) begin
            held      = 1'b1;
            host_req  = 1'b1;
            hold_left = 10;
            #1;
            check("hold_mem_en", 32'(mem_en), 32'd0);
         end
         if (rst_addr >= 0 && mem_en && mem_we && int'(mem_addr) == rst_addr) begin
            rst = 1'b1;
            #1;
            check_zero("async_rst");
            return;
         end
         if (done) begin
            lat = n;
            check("busy_on_done", 32'(busy), 32'd0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            check("start_on_done_ignored", 32'(busy), 32'd0);
            return;
         end
      end
   endtask

   initial begin
      int lat;
      int fa;
      rst      = 1'b1;
      start    = 1'b0;
      host_req = 1'b0;
      ld_en    = 1'b0;
      ld_addr  = '0;
      ld_data  = '0;
      repeat (2) @(negedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // 1: all clean
      load_clean();
      run_pass(-1, -1, lat, fa);
      check("s1_latency", 32'(lat), 32'd32);
      check("s1_first_addr", 32'(fa), 32'd0);
      check("s1_corr", 32'(corr_count), 32'd0);
      check("s1_uncorr", 32'(uncorr_count), 32'd0);

      // 2: single-bit error at addr 3
      load_clean();
      load_word(3, 32'h1234_5679);
      expect_write(3, 32'h1234_5678);
      run_pass(-1, -1, lat, fa);
      check("s2_latency", 32'(lat), 32'd33);
      check("s2_corr", 32'(corr_count), 32'd1);
      check("s2_uncorr", 32'(uncorr_count), 32'd0);
      check("s2_writes_left", 32'(exp_addr_q.size()), 32'd0);

      // 3: double-bit error at addr 5
      load_clean();
      load_word(5, 32'hE000_0005);
      run_pass(-1, -1, lat, fa);
      check("s3_latency", 32'(lat), 32'd32);
      check("s3_uncorr", 32'(uncorr_count), 32'd1);
      check("s3_last_addr", 32'(last_uncorr_addr), 32'd5);
      check("s3_flag", 32'(uncorr_flag), 32'd1);
      check("s3_corr", 32'(corr_count), 32'd0);

      // 4: host holds the port for 10 cycles during READ at addr 2
      load_clean();
      run_pass(2, -1, lat, fa);
      check("s4_latency", 32'(lat), 32'd42);
      check("s4_corr", 32'(corr_count), 32'd0);
      check("s4_uncorr", 32'(uncorr_count), 32'd0);
      check("s4_flag_cleared", 32'(uncorr_flag), 32'd0);

      // 5: reset lands while writing back addr 4; the next pass restarts at 0
      load_clean();
      load_word(4, 32'h0000_0441);
      run_pass(-1, 4, lat, fa);
      @(negedge clk);
      rst = 1'b0;
      expect_write(4, 32'h0000_0440);
      run_pass(-1, -1, lat, fa);
      check("s5_first_addr", 32'(fa), 32'd0);
      check("s5_latency", 32'(lat), 32'd33);
      check("s5_corr", 32'(corr_count), 32'd1);
      check("s5_writes_left", 32'(exp_addr_q.size()), 32'd0);

      // 6: five corrected words saturate a 2-bit counter
      load_clean();
      for (int i = 0; i < 5; i++) begin
         load_word(i, 32'h2000_0001 + 32'(i << 8));
         expect_write(i, 32'h2000_0000 + 32'(i << 8));
      end
      run_pass(-1, -1, lat, fa);
      check("s6_latency", 32'(lat), 32'd37);
      check("s6_corr_sat", 32'(corr_count), 32'd3);
      check("s6_writes_left", 32'(exp_addr_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
